// File: rtl/dcache_direct.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dcache_direct                                                |
// | Description : Direct-mapped, write-through, single-word-line data cache.   |
// |               Read hits return data combinationally with no stall. Read    |
// |               misses and all stores go to memory through a cs/stall        |
// |               handshake while the CPU is held on o_cpu_stall.              |
// |               Optional feature macro: DCACHE_WRITE_ALLOCATE_EN (a store    |
// |               miss also installs the line when the memory write ends).     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module dcache_direct #(
  parameter int          INDEX_WIDTH = 3,
  parameter logic [31:0] IDLE_ADDR   = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_cpu_req,
  input  logic        i_cpu_we,
  input  logic [31:0] i_cpu_addr,
  input  logic [31:0] i_cpu_din,
  output logic [31:0] o_cpu_dout,
  output logic        o_cpu_stall,
  output logic        o_mem_cs,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_din,
  input  logic [31:0] i_mem_dout,
  input  logic        i_mem_stall
);

  localparam int c_LINES = 1 << INDEX_WIDTH;
  localparam int c_TAG_W = 32 - INDEX_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  logic [c_LINES-1:0]  r_valid;
  logic [c_TAG_W-1:0]  r_tag  [c_LINES];
  logic [31:0]         r_data [c_LINES];
  logic [31:0]         r_addr;
  logic [31:0]         r_din;
  logic [31:0]         r_resp;
  logic                r_mem_cs;
  logic                r_mem_we;
  logic [31:0]         r_mem_addr;

  logic [INDEX_WIDTH-1:0] w_cpu_idx;
  logic [c_TAG_W-1:0]     w_cpu_tag;
  logic [INDEX_WIDTH-1:0] w_lat_idx;
  logic [c_TAG_W-1:0]     w_lat_tag;
  logic                   w_hit;
  logic                   w_fill_done;
  logic                   w_write_done;
  logic                   w_line_we;
  logic [31:0]            w_line_data;

  assign w_cpu_idx = i_cpu_addr[INDEX_WIDTH-1:0];
  assign w_cpu_tag = i_cpu_addr[31:INDEX_WIDTH];
  assign w_lat_idx = r_addr[INDEX_WIDTH-1:0];
  assign w_lat_tag = r_addr[31:INDEX_WIDTH];

  assign w_hit = r_valid[w_cpu_idx] && (r_tag[w_cpu_idx] == w_cpu_tag);

  // Memory transaction completes on the posedge that samples mem_stall low.
  assign w_fill_done  = (r_state == S_FILL)  && !i_mem_stall;
  assign w_write_done = (r_state == S_WRITE) && !i_mem_stall;

`ifdef DCACHE_WRITE_ALLOCATE_EN
  // Every completed store installs the line, hit or miss.
  assign w_line_we = w_fill_done || w_write_done;
`else
  // A store only touches the line when it already holds the same address.
  logic w_lat_hit;
  assign w_lat_hit = r_valid[w_lat_idx] && (r_tag[w_lat_idx] == w_lat_tag);
  assign w_line_we = w_fill_done || (w_write_done && w_lat_hit);
`endif

  assign w_line_data = w_fill_done ? i_mem_dout : r_din;

  assign o_mem_cs   = r_mem_cs;
  assign o_mem_we   = r_mem_we;
  assign o_mem_addr = r_mem_addr;
  assign o_mem_din  = r_din;

  // Control FSM: state, valid bits, latched request and registered memory bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_valid    <= '0;
      r_addr     <= '0;
      r_din      <= '0;
      r_resp     <= '0;
      r_mem_cs   <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= IDLE_ADDR;
    end else begin
      if (w_line_we) begin
        r_valid[w_lat_idx] <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (i_cpu_req && i_cpu_we) begin
            r_addr     <= i_cpu_addr;
            r_din      <= i_cpu_din;
            r_mem_cs   <= 1'b1;
            r_mem_we   <= 1'b1;
            r_mem_addr <= i_cpu_addr;
            r_state    <= S_WRITE;
          end else if (i_cpu_req && !w_hit) begin
            r_addr     <= i_cpu_addr;
            r_mem_cs   <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= i_cpu_addr;
            r_state    <= S_FILL;
          end
        end
        S_FILL: begin
          if (!i_mem_stall) begin
            r_resp     <= i_mem_dout;
            r_mem_cs   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= IDLE_ADDR;
            r_state    <= S_DONE;
          end
        end
        S_WRITE: begin
          if (!i_mem_stall) begin
            r_mem_cs   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= IDLE_ADDR;
            r_state    <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Tag and data storage; no reset needed because the valid bits gate every use.
  always_ff @(posedge clk) begin
    if (!rst && w_line_we) begin
      r_tag[w_lat_idx]  <= w_lat_tag;
      r_data[w_lat_idx] <= w_line_data;
    end
  end

  // CPU-side response: stall on miss/store, hit data in IDLE, captured fill data in DONE.
  always_comb begin
    o_cpu_stall = 1'b0;
    o_cpu_dout  = r_resp;
    if (!rst) begin
      case (r_state)
        S_IDLE: begin
          o_cpu_stall = i_cpu_req && (i_cpu_we || !w_hit);
          o_cpu_dout  = r_data[w_cpu_idx];
        end
        S_FILL, S_WRITE: begin
          o_cpu_stall = 1'b1;
        end
        default: begin
          o_cpu_stall = 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/dcache_direct.md
# dcache_direct

Direct-mapped, write-through, single-word-line data cache between the CPU MEM stage and the multi-cycle data memory. Read hits complete with zero stall. Read misses and all writes go to memory through a cs/stall handshake while the CPU is held on `cpu_stall`. All addresses are word addresses.

## Interface
- `INDEX_WIDTH`, 3: line index bits; the cache has 2^INDEX_WIDTH lines of one 32-bit word each.
- `IDLE_ADDR`, 32'hFFFF_FFFF: value driven on `mem_addr` whenever no memory transaction is open.

- `clk`  in  1: clock; all state updates on posedge.
- `rst`  in  1: reset, synchronous, active-high.
- `cpu_req`  in  1: access valid this cycle; held stable, with addr/we/din, while `cpu_stall`=1.
- `cpu_we`  in  1: 1=store, 0=load.
- `cpu_addr`  in  32: word address.
- `cpu_din`  in  32: store data.
- `cpu_dout`  out  32: load data; valid when `cpu_req & ~cpu_we & ~cpu_stall`.
- `cpu_stall`  out  1: CPU must hold the access and not advance.
- `mem_cs`  out  1: memory transaction open.
- `mem_we`  out  1: memory write.
- `mem_addr`  out  32: memory word address.
- `mem_din`  out  32: memory write data.
- `mem_dout`  in  32: memory read data; valid when `mem_stall`=0.
- `mem_stall`  in  1: memory busy; equals `mem_cs & ~ack`.

## Operation
- Address split: tag = `addr[31:INDEX_WIDTH]`, index = `addr[INDEX_WIDTH-1:0]`. Each line holds a valid bit, a tag and a data word.
- Hit: `valid[index]` set and the stored tag matches the address tag.
- The state machine has four states: IDLE, FILL, WRITE and DONE.
- **IDLE**
  - Read hit: `cpu_dout` = line data (combinational), `cpu_stall`=0, stay in IDLE.
  - Read miss: `cpu_stall`=1; latch the address; go to FILL.
  - Any write: `cpu_stall`=1; latch the address and data; go to WRITE.
  - `cpu_req`=0: `cpu_stall`=0, no action.
- **FILL**
  - Drive `mem_cs`=1, `mem_we`=0, `mem_addr`=latched address.
  - On a posedge with `mem_stall`=0: install the line (valid=1, tag, data=`mem_dout`), capture `mem_dout` into the response register, go to DONE.
- **WRITE**
  - Drive `mem_cs`=1, `mem_we`=1, `mem_addr`/`mem_din` = latched values.
  - On a posedge with `mem_stall`=0: go to DONE.
  - Line update on write hit: the data word is overwritten, and the valid bit and tag stay unchanged.
  - Write-miss handling depends on the configuration option below.
- **DONE**
  - `cpu_stall`=0; `cpu_dout` = response register.
  - Drive `mem_cs`=0, `mem_we`=0, `mem_addr`=`IDLE_ADDR`.
  - Go to IDLE unconditionally.
- Outside FILL and WRITE, `mem_addr`=`IDLE_ADDR` and `mem_we`=0. This guarantees an address change before every transaction, so the memory's completion flag is cleared even for back-to-back accesses to the same word.
- `mem_din` holds the latched store data in all states.

## Timing
- Reset values: state IDLE; all valid bits 0 (cleared in one cycle); `mem_cs`=0; `mem_we`=0; `mem_addr`=`IDLE_ADDR`; `mem_din`=0; response register 0; `cpu_stall`=0 while `rst`=1.
- Read hit: 0 stall cycles.
- Miss or write: stall for 1 (IDLE) + N (FILL/WRITE) + 0 (DONE) cycles, where N is the number of cycles until `mem_stall` samples low. N is 8 for the current memory. The bench must only require N ≥ 1.
- `mem_stall` is sampled only on the posedge. Memory outputs change on the negedge.
- Reset during FILL/WRITE: next state is IDLE, no line is installed, and `mem_cs` drops the following cycle. A memory write already committed is not undone.
- `cpu_req` dropping while stalled is a protocol violation and the result is undefined. The bench must not generate it.

## Configuration
- `DCACHE_WRITE_ALLOCATE_EN` defined: a write miss also installs the line at WRITE completion (valid=1, new tag, data=store data).
- `DCACHE_WRITE_ALLOCATE_EN` undefined: a write miss leaves the cache untouched (no-write-allocate).

## Test plan
- Reset, then read addr 5 (memory holds 0x0000_00AA): stall asserted, `mem_addr`=5, `mem_cs`=1. Stall releases after N+1 cycles with `cpu_dout`=0xAA. An immediate re-read of 5 hits with 0 stall cycles.
- Write 0x1234 to addr 5 after it is cached: `mem_we`=1 with `mem_din`=0x1234; `mem_addr` passes through `IDLE_ADDR` in DONE. Next read of 5 hits and returns 0x1234.
- Conflict: read 3, then read 11 (same index, INDEX_WIDTH=3), then read 3. All three miss, and each refill returns the correct memory value.
- Write miss to addr 6 with 0x55, then read 6:
  - With `DCACHE_WRITE_ALLOCATE_EN`: the read hits with 0 stall and returns 0x55.
  - Without it: the read misses and returns 0x55 from memory.
- Back-to-back writes to addr 7 (0x1, then 0x2): the second write waits the full N cycles (no stale ack). Memory ends holding 0x2.
- Assert `rst` mid-FILL: `mem_cs`=0 the next cycle. A subsequent read of the same address misses again.
